bram_access_arbiter: RTL and testbench

Sequencer and two-port arbiter for the user-area firmware BRAM. Shares the single-port, fixed-latency BRAM between the Wishbone slave path (decoded at address prefix `BASE`) and a DMA requester (FIR tap/data mover). It replaces the free-running delay counter in front of the BRAM. Each granted access is held for exactly `DELAYS` cycles and then acknowledged to its owner only.

---
 rtl/bram_arb_pkg.sv | 7 +
 rtl/bram_access_arbiter_if.sv | 42 ++++
 rtl/rr_arb2.sv | 33 +++
 rtl/bram_access_arbiter.sv | 112 +++++++++++
 tb/tb_bram_access_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding and owner constants for the BRAM arbiter
package bram_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    localparam logic OWN_WB  = 1'b0;
    localparam logic OWN_DMA = 1'b1;
    localparam logic [7:0] DEFAULT_BASE = 8'h38;
endpackage

// File: rtl/bram_access_arbiter_if.sv
// bram_access_arbiter_if: Wishbone, DMA and BRAM signal bundle around the arbiter
interface bram_access_arbiter_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        dma_req_i;
    logic        dma_we_i;
    logic [31:0] dma_adr_i;
    logic [31:0] dma_dat_i;
    logic        dma_ack_o;
    logic [31:0] dma_dat_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_adr_o;
    logic [31:0] ram_di_o;
    logic [31:0] ram_do_i;
    logic        busy_o;
    logic        owner_o;
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  dma_req_i, dma_we_i, dma_adr_i, dma_dat_i,
        output dma_ack_o, dma_dat_o,
        output ram_en_o, ram_we_o, ram_adr_o, ram_di_o,
        input  ram_do_i,
        output busy_o, owner_o
    );
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output dma_req_i, dma_we_i, dma_adr_i, dma_dat_i,
        input  dma_ack_o, dma_dat_o,
        input  ram_en_o, ram_we_o, ram_adr_o, ram_di_o,
        output ram_do_i,
        input  busy_o, owner_o
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; req[0]=WB, req[1]=DMA
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt,
    output logic       last
);
    logic last_d, last_q, fresh_d, fresh_q;

    // on a tie WB wins if it did not win last time or nobody has won since reset
    always_comb begin
        gnt     = (req == 2'b11) ? (((last_q == OWN_DMA) | fresh_q) ? 2'b01 : 2'b10) : req;
        last_d  = update ? ((gnt == 2'b10) ? OWN_DMA : OWN_WB) : last_q;
        fresh_d = fresh_q & ~update;
    end

    // latch the winner of each grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= OWN_WB;
            fresh_q <= 1'b1;
        end else begin
            last_q  <= last_d;
            fresh_q <= fresh_d;
        end
    end

    assign last = last_q;
endmodule

// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: shares a fixed-latency single-port BRAM between Wishbone and DMA
module bram_access_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned DELAYS = 10,
    parameter logic [7:0]  BASE   = DEFAULT_BASE
) (
    input logic                   clk,
    input logic                   rst,
    bram_access_arbiter_if.slave  bus
);
    localparam logic [3:0] LAST_CNT = 4'(DELAYS);

    state_t      state_d, state_q;
    logic [3:0]  cnt_d, cnt_q, sel_d, sel_q;
    logic [31:0] rdata_d, rdata_q, adr_d, adr_q, wdat_d, wdat_q;
    logic        we_d, we_q, abort_d, abort_q;
    logic        wb_ack_d, wb_ack_q, dma_ack_d, dma_ack_q;
    logic        wb_live, wb_req, own_live, update, pick_dma, owner;
    logic [1:0]  gnt;

    assign wb_live  = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign wb_req   = wb_live & (bus.wbs_adr_i[31:24] == BASE);
    assign update   = (state_q == IDLE) & (wb_req | bus.dma_req_i);
    assign pick_dma = (gnt == 2'b10);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.dma_req_i, wb_req}),
        .update (update),
        .gnt    (gnt),
        .last   (owner)
    );

    // sequencer: latch the winner, hold the window, then ack the owner unless it withdrew
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        abort_d   = abort_q;
        wb_ack_d  = 1'b0;
        dma_ack_d = 1'b0;
        own_live  = (owner == OWN_DMA) ? bus.dma_req_i : wb_live;
        if (state_q == IDLE) begin
            if (update) begin
                state_d = BUSY;
                cnt_d   = 4'd1;
                abort_d = 1'b0;
                adr_d   = pick_dma ? bus.dma_adr_i : bus.wbs_adr_i;
                wdat_d  = pick_dma ? bus.dma_dat_i : bus.wbs_dat_i;
                we_d    = pick_dma ? bus.dma_we_i : bus.wbs_we_i;
                sel_d   = pick_dma ? 4'hF : bus.wbs_sel_i;
            end
        end else if (state_q == BUSY) begin
            abort_d = abort_q | ~own_live;
            if (cnt_q == LAST_CNT) begin
                state_d   = ACK;
                rdata_d   = bus.ram_do_i;
                wb_ack_d  = (owner == OWN_WB) & ~abort_d;
                dma_ack_d = (owner == OWN_DMA) & ~abort_d;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // state and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            abort_q   <= 1'b0;
            wb_ack_q  <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            abort_q   <= abort_d;
            wb_ack_q  <= wb_ack_d;
            dma_ack_q <= dma_ack_d;
        end
    end

    // write strobes only on the first window cycle so a reset can never split a write
    assign bus.ram_en_o  = (state_q == BUSY);
    assign bus.ram_we_o  = ((state_q == BUSY) & (cnt_q == 4'd1) & we_q) ? sel_q : 4'h0;
    assign bus.ram_adr_o = adr_q;
    assign bus.ram_di_o  = wdat_q;
    assign bus.wbs_ack_o = wb_ack_q;
    assign bus.dma_ack_o = dma_ack_q;
    assign bus.wbs_dat_o = rdata_q;
    assign bus.dma_dat_o = rdata_q;
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.owner_o   = owner;
endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb_bram_access_arbiter: directed scenarios with an ack scoreboard and a BRAM model
module tb_bram_access_arbiter;
    import bram_arb_pkg::*;

    typedef struct {
        logic        who;
        logic        chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem [0:1023];
    logic [31:0] ram_do = '0;
    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0, errors = 0, cyc_n = 0;
    int          en_cnt = 0, we_cnt = 0, dack_cnt = 0, we_cyc = 0;
    logic [3:0]  we_val = '0;
    int          t, c0, c1;

    always #5 clk = ~clk;

    bram_access_arbiter_if bus();

    bram_access_arbiter #(.DELAYS(10), .BASE(8'h38)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // single-port BRAM: byte writes, registered read data
    assign bus.ram_do_i = ram_do;
    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we_o[b]) mem[bus.ram_adr_o[11:2]][8*b +: 8] <= bus.ram_di_o[8*b +: 8];
            ram_do <= mem[bus.ram_adr_o[11:2]];
        end
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // monitor: every ack must match the next expected response
    always @(negedge clk) begin
        if (bus.ram_en_o) en_cnt++;
        if (bus.dma_ack_o) dack_cnt++;
        if (bus.ram_we_o != 4'h0) begin
            we_cnt++;
            we_val = bus.ram_we_o;
            we_cyc = cyc_n;
        end
        if (!rst && (bus.wbs_ack_o || bus.dma_ack_o)) begin
            check("single_ack", {31'd0, bus.wbs_ack_o & bus.dma_ack_o}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got wb=%b dma=%b, expected none (cycle %0d)",
                         bus.wbs_ack_o, bus.dma_ack_o, cyc_n);
            end else begin
                e = exp_q.pop_front();
                check("ack_owner", {31'd0, bus.dma_ack_o}, {31'd0, e.who});
                check("ack_cycle", cyc_n, e.cyc);
                if (e.chk) begin
                    check("ack_wb_data", bus.wbs_dat_o, e.data);
                    check("ack_dma_data", bus.dma_dat_o, e.data);
                end
            end
        end
    end

    task automatic at_cycle(int n);
        while (cyc_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(logic who, logic chk, logic [31:0] data, int cyc);
        exp_t x;
        x.who  = who;
        x.chk  = chk;
        x.data = data;
        x.cyc  = cyc;
        exp_q.push_back(x);
    endtask

    task automatic wb_set(logic on, logic we, logic [31:0] adr, logic [31:0] dat);
        bus.wbs_cyc_i = on;
        bus.wbs_stb_i = on;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
    endtask

    task automatic dma_set(logic on, logic we, logic [31:0] adr, logic [31:0] dat);
        bus.dma_req_i = on;
        bus.dma_we_i  = we;
        bus.dma_adr_i = adr;
        bus.dma_dat_i = dat;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        wb_set(0, 0, '0, '0);
        dma_set(0, 0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_owner", {31'd0, bus.owner_o}, 32'd0);
        check("rst_ram_en", {31'd0, bus.ram_en_o}, 32'd0);
        check("rst_ram_we", {28'd0, bus.ram_we_o}, 32'd0);
        check("rst_wb_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("rst_dma_ack", {31'd0, bus.dma_ack_o}, 32'd0);
        check("rst_wb_dat", bus.wbs_dat_o, 32'd0);
        check("rst_ram_adr", bus.ram_adr_o, 32'd0);
        rst = 1'b0;

        // both held from the first IDLE: WB, DMA, WB at 12-cycle spacing
        t = cyc_n + 2;
        at_cycle(t);
        push(OWN_WB, 1'b1, 32'h0, t + 11);
        push(OWN_DMA, 1'b0, 32'h0, t + 23);
        push(OWN_WB, 1'b1, 32'h0, t + 35);
        wb_set(1, 0, 32'h3800_0020, '0);
        dma_set(1, 1, 32'h0000_0040, 32'h1234_5678);
        at_cycle(t + 35);
        wb_set(0, 0, '0, '0);
        dma_set(0, 0, '0, '0);

        // WB write: one write-strobe cycle on the first window cycle
        t = cyc_n + 2;
        at_cycle(t);
        c0 = we_cnt;
        push(OWN_WB, 1'b0, 32'h0, t + 11);
        wb_set(1, 1, 32'h3800_0010, 32'hDEAD_BEEF);
        at_cycle(t + 11);
        wb_set(0, 0, '0, '0);
        at_cycle(t + 13);
        check("wr_we_pulses", we_cnt - c0, 32'd1);
        check("wr_we_value", {28'd0, we_val}, 32'hF);
        check("wr_we_cycle", we_cyc, t + 1);

        // WB readback, DMA never acked
        t = cyc_n + 2;
        at_cycle(t);
        c0 = dack_cnt;
        push(OWN_WB, 1'b1, 32'hDEAD_BEEF, t + 11);
        wb_set(1, 0, 32'h3800_0010, '0);
        at_cycle(t + 11);
        wb_set(0, 0, '0, '0);
        at_cycle(t + 13);
        check("rd_no_dma_ack", dack_cnt - c0, 32'd0);

        // non-decoded WB cycle is ignored; DMA alongside it is served
        t = cyc_n + 2;
        at_cycle(t);
        c1 = en_cnt;
        wb_set(1, 0, 32'h3000_0000, '0);
        at_cycle(t + 20);
        check("nd_no_en", en_cnt - c1, 32'd0);
        check("nd_not_busy", {31'd0, bus.busy_o}, 32'd0);
        push(OWN_DMA, 1'b1, 32'h1234_5678, t + 31);
        dma_set(1, 0, 32'h0000_0040, '0);
        at_cycle(t + 31);
        dma_set(0, 0, '0, '0);
        at_cycle(t + 33);
        wb_set(0, 0, '0, '0);
        check("nd_dma_window", en_cnt - c1, 32'd10);

        // WB withdraws mid-window: window completes, no ack, pending DMA follows
        t = cyc_n + 2;
        at_cycle(t);
        wb_set(1, 0, 32'h3800_0010, '0);
        at_cycle(t + 3);
        wb_set(0, 0, '0, '0);
        push(OWN_DMA, 1'b0, 32'h0, t + 23);
        dma_set(1, 1, 32'h0000_0080, 32'hA5A5_5A5A);
        at_cycle(t + 10);
        check("ab_busy_end", {31'd0, bus.busy_o}, 32'd1);
        check("ab_en_end", {31'd0, bus.ram_en_o}, 32'd1);
        check("ab_owner_wb", {31'd0, bus.owner_o}, 32'd0);
        at_cycle(t + 11);
        check("ab_no_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        at_cycle(t + 14);
        check("ab_owner_dma", {31'd0, bus.owner_o}, 32'd1);
        at_cycle(t + 23);
        dma_set(0, 0, '0, '0);

        // reset in the fifth window cycle, then WB wins the first tie again
        t = cyc_n + 2;
        at_cycle(t);
        wb_set(1, 0, 32'h3800_0010, '0);
        at_cycle(t + 5);
        rst = 1'b1;
        at_cycle(t + 6);
        check("mr_idle", {31'd0, bus.busy_o}, 32'd0);
        check("mr_no_en", {31'd0, bus.ram_en_o}, 32'd0);
        check("mr_no_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        rst = 1'b0;
        wb_set(0, 0, '0, '0);
        t = cyc_n + 2;
        at_cycle(t);
        push(OWN_WB, 1'b1, 32'hDEAD_BEEF, t + 11);
        push(OWN_DMA, 1'b1, 32'hA5A5_5A5A, t + 23);
        wb_set(1, 0, 32'h3800_0010, '0);
        dma_set(1, 0, 32'h0000_0080, '0);
        at_cycle(t + 11);
        wb_set(0, 0, '0, '0);
        at_cycle(t + 23);
        dma_set(0, 0, '0, '0);
        at_cycle(t + 26);

        check("all_acks_seen", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
